// File: rtl/gb_fill_cntl.sv
// Fill controller: fetches one batch of words through iocntl into the activation
// write bank, then hands the bank to the MAC array via swap and waits for mac_done.
module gb_fill_cntl #(
  parameter int BATCH_SIZE = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ACT_DEPTH  = 128
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             process_valid,
  output logic                             process_active,
  output logic                             process_done,
  input  logic [BATCH_SIZE*ADDR_WIDTH-1:0] process_raddr,
  output logic [BATCH_SIZE*ADDR_WIDTH-1:0] process_waddr,
  output logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic                             rd_req,
  input  logic                             rd_gnt,
  input  logic                             rd_valid,
  input  logic [DATA_WIDTH-1:0]            rd_data,
  output logic [$clog2(ACT_DEPTH)-1:0]     act_waddr,
  output logic                             act_wen,
  output logic [DATA_WIDTH-1:0]            act_wdata,
  output logic                             swap,
  input  logic                             mac_done,
  output logic                             protocol_err
);

  // state   | meaning
  // IDLE    | waiting for process_valid
  // REQ     | rd_req up for addr[idx], waiting for grant
  // WAIT    | read granted, waiting for rd_valid
  // WRITE   | captured word written to act bank at idx
  // SWAP    | one-cycle swap pulse
  // COMPUTE | waiting for mac_done
  // DONE    | one-cycle process_done pulse

  localparam int IDX_W  = $clog2(BATCH_SIZE);
  localparam int ACT_AW = $clog2(ACT_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WRITE,
    S_SWAP,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [BATCH_SIZE-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  capture;
  logic                  last_word;
  logic                  rd_valid_bad;

  assign process_waddr = addr_q;
  assign last_word     = (idx == IDX_W'(BATCH_SIZE - 1));

  // Data is only legal while a read is outstanding, or when it lands with the grant.
  assign rd_valid_bad = rd_valid && (state != S_WAIT) && !((state == S_REQ) && rd_gnt);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    process_active = 1'b0;
    process_done   = 1'b0;
    rd_req         = 1'b0;
    rd_addr        = '0;
    act_wen        = 1'b0;
    act_waddr      = '0;
    act_wdata      = '0;
    swap           = 1'b0;
    capture        = 1'b0;
    case (state)
      S_IDLE: begin
        if (process_valid) state_nxt = S_REQ;
      end
      S_REQ: begin
        process_active = 1'b1;
        rd_req         = 1'b1;
        rd_addr        = addr_q[idx];
        if (rd_gnt && rd_valid) begin
          capture   = 1'b1;
          state_nxt = S_WRITE;
        end else if (rd_gnt) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        process_active = 1'b1;
        if (rd_valid) begin
          capture   = 1'b1;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        process_active = 1'b1;
        act_wen        = 1'b1;
        act_waddr      = ACT_AW'(idx);
        act_wdata      = data_q;
        state_nxt      = last_word ? S_SWAP : S_REQ;
      end
      S_SWAP: begin
        process_active = 1'b1;
        swap           = 1'b1;
        state_nxt      = S_COMPUTE;
      end
      S_COMPUTE: begin
        process_active = 1'b1;
        if (mac_done) state_nxt = S_DONE;
      end
      S_DONE: begin
        process_done = 1'b1;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q       <= '0;
      idx          <= '0;
      data_q       <= '0;
      protocol_err <= 1'b0;
    end else begin
      if ((state == S_IDLE) && process_valid) begin
        addr_q <= process_raddr;
        idx    <= '0;
      end
      if (capture) data_q <= rd_data;
      if ((state == S_WRITE) && !last_word) idx <= idx + IDX_W'(1);
      if (rd_valid_bad) protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gb_fill_cntl.sv
// Directed bench for gb_fill_cntl: an iocntl responder model plus a scoreboard
// of expected act-bank writes popped by a negedge monitor.
module tb_gb_fill_cntl;
  localparam int BS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int AD = 8;
  localparam int WA = $clog2(AD);

  logic           clock = 1'b0;
  logic           reset;
  logic           process_valid;
  logic           process_active;
  logic           process_done;
  logic [BS*AW-1:0] process_raddr;
  logic [BS*AW-1:0] process_waddr;
  logic [AW-1:0]  rd_addr;
  logic           rd_req;
  logic           rd_gnt;
  logic           rd_valid;
  logic [DW-1:0]  rd_data;
  logic [WA-1:0]  act_waddr;
  logic           act_wen;
  logic [DW-1:0]  act_wdata;
  logic           swap;
  logic           mac_done;
  logic           protocol_err;

  logic           model_valid;
  logic [DW-1:0]  model_data;
  logic           inj_valid;
  logic [DW-1:0]  inj_data;

  assign rd_valid = model_valid | inj_valid;
  assign rd_data  = inj_valid ? inj_data : model_data;

  gb_fill_cntl #(
    .BATCH_SIZE(BS),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ACT_DEPTH (AD)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .process_valid (process_valid),
    .process_active(process_active),
    .process_done  (process_done),
    .process_raddr (process_raddr),
    .process_waddr (process_waddr),
    .rd_addr       (rd_addr),
    .rd_req        (rd_req),
    .rd_gnt        (rd_gnt),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .act_waddr     (act_waddr),
    .act_wen       (act_wen),
    .act_wdata     (act_wdata),
    .swap          (swap),
    .mac_done      (mac_done),
    .protocol_err  (protocol_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct packed {
    logic [WA-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  total = 0;
  int  bad = 0;
  int  wen_cnt = 0;
  int  swap_cnt = 0;
  int  done_cnt = 0;
  int  first_wen = 0;
  int  last_wen = 0;

  // Monitor: every act write must match the head of the expectation queue.
  always @(negedge clock) begin
    if (act_wen) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL act_write_unexpected: got addr=%0d data=%h, required no write", act_waddr, act_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (act_waddr !== mon_e.a || act_wdata !== mon_e.d) begin
          bad++;
          $display("FAIL act_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   act_waddr, act_wdata, mon_e.a, mon_e.d);
        end
      end
      if (wen_cnt == 0) first_wen = cyc;
      last_wen = cyc;
      wen_cnt++;
    end
    if (swap) swap_cnt++;
    if (process_done) done_cnt++;
  end

  // iocntl responder: data word is always the requested address plus one.
  int stall_left = 0;
  bit coincide = 1'b0;
  initial begin
    rd_gnt = 1'b0;
    model_valid = 1'b0;
    model_data = '0;
    forever begin
      @(posedge clock); #1;
      rd_gnt = 1'b0;
      model_valid = 1'b0;
      if (rd_req && !reset) begin
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          rd_gnt = 1'b1;
          model_data = rd_addr + 32'd1;
          if (coincide) begin
            model_valid = 1'b1;
          end else begin
            @(posedge clock); #1;
            rd_gnt = 1'b0;
            @(posedge clock); #1;
            if (!reset) model_valid = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic start_batch(input logic [BS*AW-1:0] addrs);
    wr_t e;
    logic [AW-1:0] a;
    for (int i = 0; i < BS; i++) begin
      a = addrs[i*AW +: AW];
      e.a = WA'(i);
      e.d = a + 32'd1;
      exp_q.push_back(e);
    end
    wen_cnt = 0;
    swap_cnt = 0;
    done_cnt = 0;
    process_raddr = addrs;
    process_valid = 1'b1;
    tick();
    process_valid = 1'b0;
  endtask

  task automatic wait_swap(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (swap) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got no swap in 300 cycles, required swap pulse", name);
    end
  endtask

  task automatic finish_batch(input string name);
    chk({name, " queue_drained"}, exp_q.size(), 0);
    tick();
    tick();
    chk({name, " compute_active"}, process_active, 1);
    chk({name, " compute_no_done"}, process_done, 0);
    mac_done = 1'b1;
    tick();
    mac_done = 1'b0;
    chk({name, " done_pulse"}, process_done, 1);
    chk({name, " done_inactive"}, process_active, 0);
    tick();
    chk({name, " done_cleared"}, process_done, 0);
    chk({name, " swap_count"}, swap_cnt, 1);
    chk({name, " done_count"}, done_cnt, 1);
  endtask

  logic [BS*AW-1:0] a1, a2, a3, a3_alt, a5, a6;

  initial begin
    a1     = {32'h40, 32'h30, 32'h20, 32'h10};
    a2     = {32'h400, 32'h300, 32'h200, 32'h100};
    a3     = {32'hC000_0040, 32'hC000_0030, 32'hC000_0020, 32'hC000_0010};
    a3_alt = {32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888};
    a5     = {32'h0BAD_0004, 32'h0BAD_0003, 32'h0BAD_0002, 32'h0BAD_0001};
    a6     = {32'hA6, 32'hA5, 32'hA4, 32'hA3};

    reset = 1'b1;
    process_valid = 1'b0;
    process_raddr = '0;
    mac_done = 1'b0;
    inj_valid = 1'b0;
    inj_data = '0;
    repeat (3) tick();
    chk("reset active", process_active, 0);
    chk("reset rd_req", rd_req, 0);
    chk("reset waddr", process_waddr, 0);
    chk("reset perr", protocol_err, 0);
    chk("reset act_wen", act_wen, 0);
    reset = 1'b0;
    tick();

    // 1: gnt next cycle, valid two cycles later
    coincide = 1'b0;
    start_batch(a1);
    chk("t1 active", process_active, 1);
    chk("t1 first rd_addr", rd_addr, 32'h10);
    wait_swap("t1 swap");
    chk("t1 wen_count", wen_cnt, 4);
    chk("t1 write_span", last_wen - first_wen, 12);
    finish_batch("t1");
    chk("t1 waddr", process_waddr, a1);

    // 2: grant and data together
    coincide = 1'b1;
    start_batch(a2);
    wait_swap("t2 swap");
    chk("t2 wen_count", wen_cnt, 4);
    chk("t2 write_span", last_wen - first_wen, 6);
    finish_batch("t2");

    // 3: stray mac_done and process_valid mid-batch
    coincide = 1'b0;
    start_batch(a3);
    repeat (3) tick();
    mac_done = 1'b1;
    process_valid = 1'b1;
    process_raddr = a3_alt;
    tick();
    mac_done = 1'b0;
    process_valid = 1'b0;
    chk("t3 waddr_mid", process_waddr, a3);
    chk("t3 active_mid", process_active, 1);
    wait_swap("t3 swap");
    chk("t3 no_early_done", done_cnt, 0);
    chk("t3 waddr_stable", process_waddr, a3);
    finish_batch("t3");

    // 4: rd_valid while idle
    chk("t4 perr_before", protocol_err, 0);
    wen_cnt = 0;
    inj_data = 32'hDEAD;
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    chk("t4 perr_set", protocol_err, 1);
    chk("t4 idle", process_active, 0);
    repeat (5) tick();
    chk("t4 perr_sticky", protocol_err, 1);
    chk("t4 no_wen", wen_cnt, 0);
    chk("t4 no_req", rd_req, 0);

    // 6: grant stalled for 10 cycles
    coincide = 1'b0;
    stall_left = 10;
    start_batch(a6);
    for (int k = 0; k < 10; k++) begin
      chk("t6 rd_req_held", rd_req, 1);
      chk("t6 rd_addr_held", rd_addr, 32'hA3);
      chk("t6 no_wen", act_wen, 0);
      if (k < 9) tick();
    end
    wait_swap("t6 swap");
    chk("t6 wen_count", wen_cnt, 4);
    finish_batch("t6");
    chk("t6 perr_still", protocol_err, 1);

    // 5: reset while in WAIT at idx 2
    coincide = 1'b0;
    start_batch(a5);
    for (int i = 0; i < 100 && wen_cnt < 2; i++) tick();
    chk("t5 reached_idx2", wen_cnt, 2);
    tick();
    chk("t5 in_wait_req", rd_req, 0);
    chk("t5 in_wait_active", process_active, 1);
    reset = 1'b1;
    #1;
    chk("t5 rst active", process_active, 0);
    chk("t5 rst rd_req", rd_req, 0);
    chk("t5 rst rd_addr", rd_addr, 0);
    chk("t5 rst act_wen", act_wen, 0);
    chk("t5 rst swap", swap, 0);
    chk("t5 rst done", process_done, 0);
    chk("t5 rst waddr", process_waddr, 0);
    chk("t5 rst perr", protocol_err, 0);
    exp_q.delete();
    swap_cnt = 0;
    done_cnt = 0;
    repeat (3) tick();
    chk("t5 no_swap_done", swap_cnt + done_cnt, 0);
    reset = 1'b0;
    tick();
    start_batch(a1);
    wait_swap("t5 swap");
    chk("t5 wen_count", wen_cnt, 4);
    chk("t5 perr_clear", protocol_err, 0);
    finish_batch("t5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
